// File: rtl/mem_access_unit_if.sv
// Request, response and word-memory signals of the load/store unit.
// slave is the unit's view; master is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        opcode;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       load_data;
  logic              misalign_err;
  logic              illegal_op;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, opcode, addr, wdata, mem_rdata,
    output req_ready, resp_valid, load_data, misalign_err, illegal_op,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport master (
    output req_valid, opcode, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, load_data, misalign_err, illegal_op,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store front end: one request at a time, sub-word stores by read-modify-write.
// Response 1 (error), 2 (sw), 3 (loads) or 4 (sb/sh) cycles after accept; req_ready only in IDLE.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              misalign_q, misalign_d;
  logic              illegal_q, illegal_d;

  logic              in_known, in_half, in_word, in_misalign;
  logic              cur_store, cur_byte, cur_half, cur_signed;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_ext;
  logic [31:0]       merged;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  // Classification of the opcode presented for acceptance
  always_comb begin
    in_known = 1'b0;
    in_half  = 1'b0;
    in_word  = 1'b0;
    case (bus.opcode)
      OP_LB, OP_LBU, OP_SB: in_known = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        in_known = 1'b1;
        in_half  = 1'b1;
      end
      OP_LW, OP_SW: begin
        in_known = 1'b1;
        in_word  = 1'b1;
      end
      default: in_known = 1'b0;
    endcase
    in_misalign = (in_half && bus.addr[0]) || (in_word && (bus.addr[1:0] != 2'b00));
  end

  // Classification of the registered opcode
  always_comb begin
    cur_store  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    cur_byte   = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
    cur_half   = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
    cur_signed = (op_q == OP_LB) || (op_q == OP_LH);
  end

  // Lane selection and extension for loads, lane replacement for sb/sh
  always_comb begin
    rd_byte = bus.mem_rdata[7:0];
    merged  = bus.mem_rdata;
    case (off_q)
      2'd0: begin
        rd_byte      = bus.mem_rdata[7:0];
        merged[7:0]  = word_q[7:0];
      end
      2'd1: begin
        rd_byte      = bus.mem_rdata[15:8];
        merged[15:8] = word_q[7:0];
      end
      2'd2: begin
        rd_byte       = bus.mem_rdata[23:16];
        merged[23:16] = word_q[7:0];
      end
      default: begin
        rd_byte       = bus.mem_rdata[31:24];
        merged[31:24] = word_q[7:0];
      end
    endcase
    rd_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    if (cur_half) begin
      merged = off_q[1] ? {word_q[15:0], bus.mem_rdata[15:0]}
                        : {bus.mem_rdata[31:16], word_q[15:0]};
    end
    if (cur_byte) begin
      rd_ext = {{24{cur_signed & rd_byte[7]}}, rd_byte};
    end else if (cur_half) begin
      rd_ext = {{16{cur_signed & rd_half[15]}}, rd_half};
    end else begin
      rd_ext = bus.mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    widx_d      = widx_q;
    off_d       = off_q;
    word_d      = word_q;
    load_data_d = load_data_q;
    misalign_d  = misalign_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d       = bus.opcode;
          widx_d     = bus.addr[ADDR_W+1:2];
          off_d      = bus.addr[1:0];
          word_d     = bus.wdata;
          misalign_d = in_misalign;
          illegal_d  = !in_known;
          if (!in_known || in_misalign) begin
            load_data_d = '0;
            state_d     = S_RESP;
          end else if (bus.opcode == OP_SW) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (cur_store) begin
          word_d  = merged;
          state_d = S_WR;
        end else begin
          load_data_d = rd_ext;
          state_d     = S_RESP;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops strobes at once
  always_comb begin
    bus.req_ready    = (state_q == S_IDLE);
    bus.resp_valid   = (state_q == S_RESP);
    bus.load_data    = load_data_q;
    bus.misalign_err = 1'b0;
    bus.illegal_op   = 1'b0;
    bus.mem_rd_en    = (state_q == S_RD);
    bus.mem_wr_en    = (state_q == S_WR);
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (state_q == S_RESP) begin
      bus.misalign_err = misalign_q;
      bus.illegal_op   = illegal_q;
      if (cur_store) begin
        bus.load_data = '0;
      end
    end
    if ((state_q == S_RD) || (state_q == S_WR)) begin
      bus.mem_addr = widx_q;
    end
    if (state_q == S_WR) begin
      bus.mem_wdata = word_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      widx_q      <= '0;
      off_q       <= '0;
      word_q      <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      widx_q      <= widx_d;
      off_q       <= off_d;
      word_q      <= word_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and an expected-response queue.
module tb_mem_access_unit;

  localparam int ADDR_W = 8;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        ill;
    int          lat;
    int          rd_c;
    int          wr_c;
    logic [7:0]  maddr;
    logic [31:0] wdat;
    bit          abort;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   active = 1'b0;
  int   rel = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;

  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_dat = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expectation at accept, then checks strobes and the response against it
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (active) begin
          chk("abort_expected", {31'b0, cur.abort}, 32'd1);
          chk("abort_wr_count", wr_seen, 0);
          chk("abort_rd_count", rd_seen, cur.rd_c != 0);
          active = 1'b0;
        end
      end else begin
        if (bus.mem_rd_en && bus.mem_wr_en) begin
          n_fail++;
          $display("FAIL strobe_overlap: rd_en=1 wr_en=1 required at most one");
        end
        if (active) begin
          rel++;
          if (bus.mem_rd_en) begin
            rd_seen++;
            chk("rd_cycle", rel, cur.rd_c);
            chk("rd_addr", {24'b0, bus.mem_addr}, {24'b0, cur.maddr});
          end
          if (bus.mem_wr_en) begin
            wr_seen++;
            chk("wr_cycle", rel, cur.wr_c);
            chk("wr_addr", {24'b0, bus.mem_addr}, {24'b0, cur.maddr});
            chk("wr_data", bus.mem_wdata, cur.wdat);
          end
          if (bus.resp_valid) begin
            chk("resp_on_aborted", {31'b0, cur.abort}, 32'd0);
            chk("resp_latency", rel, cur.lat);
            chk("load_data", bus.load_data, cur.ld);
            chk("misalign_err", {31'b0, bus.misalign_err}, {31'b0, cur.mis});
            chk("illegal_op", {31'b0, bus.illegal_op}, {31'b0, cur.ill});
            chk("rd_count", rd_seen, cur.rd_c != 0);
            chk("wr_count", wr_seen, cur.wr_c != 0);
            active = 1'b0;
          end else if (rel > 8) begin
            n_fail++;
            $display("FAIL resp_timeout: no resp_valid after %0d cycles, required %0d", rel, cur.lat);
            active = 1'b0;
          end
        end else if (bus.mem_rd_en || bus.mem_wr_en || bus.resp_valid) begin
          n_fail++;
          $display("FAIL spurious_output: rd=%0b wr=%0b resp=%0b with no request in flight, required 0",
                   bus.mem_rd_en, bus.mem_wr_en, bus.resp_valid);
        end
        if (bus.req_valid && bus.req_ready) begin
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL accept_unexpected: accept seen with empty queue, required none");
          end else begin
            cur     = q.pop_front();
            active  = 1'b1;
            rel     = 0;
            rd_seen = 0;
            wr_seen = 0;
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] ld, input logic mis, input logic ill, input int lat,
                      input int rd_c, input int wr_c, input logic [7:0] maddr,
                      input logic [31:0] wdat, input bit abort);
    exp_t e;
    e.ld = ld; e.mis = mis; e.ill = ill; e.lat = lat; e.rd_c = rd_c; e.wr_c = wr_c;
    e.maddr = maddr; e.wdat = wdat; e.abort = abort;
    q.push_back(e);
  endtask

  // Presents a request and returns one cycle after the accept edge, req_valid still high
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    bus.opcode    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc;
        got = 1'b1;
      end
    end
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready=0 after 20 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (active || q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    if (active || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size() + int'(active));
      q.delete();
      active = 1'b0;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ld, input logic mis, input logic ill, input int lat,
                     input int rd_c, input int wr_c, input logic [7:0] maddr, input logic [31:0] wdat);
    int acc;
    push(ld, mis, ill, lat, rd_c, wr_c, maddr, wdat, 1'b0);
    drive(op, a, wd, acc);
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},    {31'b0, bus.req_ready}, 32'd1);
    chk({tag, "_resp_valid"},   {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, "_load_data"},    bus.load_data, 32'd0);
    chk({tag, "_misalign_err"}, {31'b0, bus.misalign_err}, 32'd0);
    chk({tag, "_illegal_op"},   {31'b0, bus.illegal_op}, 32'd0);
    chk({tag, "_mem_rd_en"},    {31'b0, bus.mem_rd_en}, 32'd0);
    chk({tag, "_mem_wr_en"},    {31'b0, bus.mem_wr_en}, 32'd0);
    chk({tag, "_mem_addr"},     {24'b0, bus.mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"},    bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int a1, a2;
    bus.req_valid = 1'b0;
    bus.opcode    = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    bd_we = 1'b1; bd_addr = 8'd5; bd_dat = 32'h8899AABB;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Loads from word 5 = 0x8899AABB
    run(OP_LB,  32'h15, 32'h0, 32'hFFFFFFAA, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    run(OP_LBU, 32'h15, 32'h0, 32'h000000AA, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    run(OP_LH,  32'h14, 32'h0, 32'hFFFFAABB, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    run(OP_LHU, 32'h16, 32'h0, 32'h00008899, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    run(OP_LW,  32'h14, 32'h0, 32'h8899AABB, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    // Read-modify-write stores, word restored between them
    run(OP_SH,  32'h16, 32'hDEAD1234, 32'h0, 0, 0, 4, 1, 3, 8'd5, 32'h1234AABB);
    bd_we = 1'b1; bd_addr = 8'd5; bd_dat = 32'h8899AABB;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    run(OP_SB,  32'h17, 32'h0000007F, 32'h0, 0, 0, 4, 1, 3, 8'd5, 32'h7F99AABB);
    // Positive byte in the top lane: no sign extension
    run(OP_LB,  32'h17, 32'h0, 32'h0000007F, 0, 0, 3, 1, 0, 8'd5, 32'h0);
    // Misaligned and illegal requests
    run(OP_LW,  32'h13, 32'h0, 32'h0, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    run(OP_SH,  32'h11, 32'h0, 32'h0, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    run(6'h3F,  32'h14, 32'h0, 32'h0, 0, 1, 1, 0, 0, 8'd0, 32'h0);

    // sw followed by a held lw: second accept three cycles after the first
    push(32'h0, 0, 0, 2, 0, 1, 8'd2, 32'hCAFEF00D, 1'b0);
    push(32'hCAFEF00D, 0, 0, 3, 1, 0, 8'd2, 32'h0, 1'b0);
    drive(OP_SW, 32'h08, 32'hCAFEF00D, a1);
    drive(OP_LW, 32'h08, 32'h0, a2);
    bus.req_valid = 1'b0;
    chk("b2b_accept_gap", a2 - a1, 3);
    drain();

    // sb interrupted by reset during WAIT: no write, no response
    push(32'h0, 0, 0, 4, 1, 3, 8'd5, 32'h7F99AA11, 1'b1);
    drive(OP_SB, 32'h14, 32'h00000011, a1);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    check_reset_outputs("abort_held");
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_queue_empty", q.size(), 0);
    run(OP_LW, 32'h14, 32'h0, 32'h7F99AABB, 0, 0, 3, 1, 0, 8'd5, 32'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the MIPS datapath, placed between the EX/MEM pipeline register and the word-wide data memory. It takes one load or store request at a time and issues word-granular memory reads and writes. Sub-word stores (sb/sh) are done as a read-modify-write. Load results are aligned and sign- or zero-extended, and misaligned or illegal requests are flagged without touching memory.

## Interface
Parameters:
- ADDR_W, 8, word-index width of the memory port (memory depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- opcode  in  6  MIPS opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B
- addr  in  32  byte address; bits [ADDR_W+1:2] are the word index, bits [1:0] the byte offset, higher bits ignored
- wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse, request complete
- load_data  out  32  extended load result, valid with resp_valid
- misalign_err  out  1  valid with resp_valid
- illegal_op  out  1  valid with resp_valid; opcode not in list
- mem_addr  out  ADDR_W  word index to memory
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, valid the cycle after mem_rd_en

## Operation
- Byte lanes are little-endian: offset 0 is bits [7:0] and offset 3 is bits [31:24]. A halfword at offset 2 is bits [31:16].
- A request is accepted on the edge where req_valid and req_ready are both high. At that edge the unit registers opcode, addr and wdata.
- Checks made at accept:
  - Halfword ops with addr[0]=1 are misaligned.
  - Word ops with addr[1:0]≠0 are misaligned.
  - An unknown opcode is illegal.
  - Either error sends the state machine straight to RESP. No mem_rd_en or mem_wr_en is issued, load_data=0, and the matching error flag is set.
- State machine (IDLE, RD, WAIT, WR, RESP):
  - IDLE: req_ready=1. On accept:
    - sw goes to WR.
    - Loads, sb and sh go to RD.
    - Errors go to RESP.
  - RD: mem_rd_en=1 and mem_addr=word index. Next state is WAIT.
  - WAIT: mem_rdata is sampled.
    - Loads: select the lane, then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw passes the word through. Register the result into load_data and go to RESP.
    - sb/sh: replace the addressed lane(s) with wdata[7:0] or wdata[15:0], keep the other bytes, register the merged word, and go to WR.
  - WR: mem_wr_en=1, mem_addr=word index, and mem_wdata=merged word (sw: wdata). Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle. Next state is IDLE.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Each request produces at most one memory read and one memory write.
- mem_addr and mem_wdata are don't-care when no strobe is high; they are driven 0 in IDLE.
- load_data holds its value until the next load or error response. Store responses drive load_data=0.
- Error flags are 0 on every response except the one that caused them.

## Timing
- Reset values: req_ready=1 (state IDLE), resp_valid=0, load_data=0, misalign_err=0, illegal_op=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Cycles below count from the accept edge, with cycle 1 the first cycle after it.
- resp_valid latency:
  - Error: resp_valid in cycle 1.
  - sw: mem_wr_en in cycle 1, resp_valid in cycle 2.
  - Loads: mem_rd_en in cycle 1, rdata sampled in cycle 2, resp_valid in cycle 3.
  - sb/sh: mem_rd_en in cycle 1, merge in cycle 2, mem_wr_en in cycle 3, resp_valid in cycle 4.
- req_ready falls in cycle 1 and returns in the cycle after RESP. There is no back-to-back accept, and throughput is one request per 2–5 cycles.
- req_valid high while req_ready is low is ignored. The requester holds the request until it is accepted.
- resp_valid does not wait for the consumer; the pipeline must capture it in that cycle.
- Reset asserted mid-operation:
  - The state returns to IDLE immediately, and strobes drop in the same cycle.
  - A read-modify-write interrupted before WR issues no write.
  - No resp_valid is ever produced for an aborted request.

## Test plan
- Memory word 5 = 0x8899AABB:
  - lb at addr 0x15 -> one mem_rd_en with mem_addr=5; resp_valid in cycle 3 with load_data=0xFFFFFFAA.
  - lbu at addr 0x15 -> load_data=0x000000AA.
- lh at 0x14 -> load_data 0xFFFFAABB. lhu at 0x16 -> load_data 0x00008899. lw at 0x14 -> load_data 0x8899AABB.
- sh at addr 0x16 with wdata=0xDEAD1234, word 5 = 0x8899AABB -> mem_rd_en in cycle 1; mem_wr_en in cycle 3 with mem_wdata=0x1234AABB; resp_valid in cycle 4. sb at 0x17 with wdata 0x7F -> mem_wdata 0x7F99AABB.
- lw at 0x13; then sh at 0x11; then opcode 0x3F -> no memory strobes in any case. resp_valid in cycle 1 each time: misalign_err=1 for the first two, illegal_op=1 for the third. load_data=0 throughout.
- sw at 0x08 with wdata 0xCAFEF00D -> mem_wr_en in cycle 1, mem_addr=2, mem_wdata=0xCAFEF00D, resp_valid in cycle 2. Hold req_valid high -> next accept occurs in cycle 3.
- sb accepted, reset pulsed during WAIT -> mem_wr_en never asserts, resp_valid never asserts, all outputs at reset values. req_ready=1 after reset and a new lw completes normally.
